vector_engine: RTL and testbench
================================

Name: vector_engine

Overview:
- Parametrised, multi-cycle vector load/store/ALU engine with a private element-addressed scratch memory and a vector register file.
- Accepts one command at a time over a valid/ready handshake.
- Executes each command in LANES_PER_BEAT-wide beats and reports completion or error.
- Intended next-generation core of the vector datapath; replaces single-cycle, fixed-size operation with configurable lanes, registers and throughput.

Parameters:
- NUM_REGS, 4, number of vector registers (power of two, >=2); REG_AW = clog2(NUM_REGS)
- LANES, 16, elements per vector
- ELEM_W, 32, element width in bits
- MEM_DEPTH, 512, memory depth in elements (power of two); MEM_AW = clog2(MEM_DEPTH)
- LANES_PER_BEAT, 4, elements processed per cycle; LANES % LANES_PER_BEAT == 0; BEATS = LANES/LANES_PER_BEAT

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  000 LOAD, 001 STORE, 010 ADD, 011 MUL, 100 SUB, others illegal
- cmd_addr  in  MEM_AW  base element address (LOAD/STORE only)
- cmd_rd  in  REG_AW  destination register (LOAD/ADD/MUL/SUB); source register for STORE
- cmd_rs1  in  REG_AW  first ALU source
- cmd_rs2  in  REG_AW  second ALU source
- done  out  1  one-cycle pulse, command finished (normally or with error)
- err  out  1  one-cycle pulse coincident with done when the command was rejected
- busy  out  1  command executing
- host_we  in  1  host memory write strobe
- host_addr  in  MEM_AW  host write address
- host_wdata  in  ELEM_W  host write data
- dbg_mem_addr  in  MEM_AW  memory peek address
- dbg_mem_data  out  ELEM_W  combinational memory peek
- dbg_reg  in  REG_AW  register peek select
- dbg_lane  in  clog2(LANES)  lane peek select
- dbg_reg_data  out  ELEM_W  combinational register-lane peek

Behaviour:
- Reset (rst_n low at edge): state IDLE, beat counter 0, all register lanes 0, done=0, err=0, busy=0; cmd_ready=0 while rst_n low, 1 otherwise when IDLE. Memory contents are not cleared.
- Reset mid-command: aborts immediately. Memory beats already committed by a STORE remain written; no done pulse.
- FSM IDLE -> EXEC on acceptance; EXEC -> IDLE after beat BEATS-1 commits. Rejected commands stay in IDLE.
- Latched at acceptance: op, addr, rd, rs1, rs2. Inputs are don't-care afterwards.
- Timing: command accepted at edge T0. Beat b (0..BEATS-1) processes lanes [b*LANES_PER_BEAT +: LANES_PER_BEAT] and commits at edge T0+1+b. done=1 and cmd_ready=1 in the cycle after edge T0+BEATS. busy=1 from T0 through edge T0+BEATS.
- Command latency: BEATS+1 cycles, accept to done.
- LOAD: reg[rd] lane i <= mem[addr+i].
- STORE: mem[addr+i] <= reg[rd] lane i.
- Bound check on LOAD/STORE: addr + LANES > MEM_DEPTH means reject. The next cycle has done=1, err=1, no state change, engine stays IDLE. Address never wraps.
- Illegal op (101-111): same reject behaviour. ADD/MUL/SUB ignore cmd_addr and are never bound-rejected.
- ADD/SUB: reg[rd] lane i <= rs1_i +/- rs2_i modulo 2^ELEM_W (unsigned wrap).
- MUL: unsigned 2*ELEM_W product. Low half goes to reg[rd] lane i; high half goes to reg[(rd+1) mod NUM_REGS] lane i.
- Operand overlap: each beat reads and writes only its own lane slice, so rd==rs1/rs2 (including MUL high-half target) gives element-wise correct results using original operand values.
- Memory reads are combinational. Each beat's writes commit on its edge.
- host_we is honoured only when IDLE (including the acceptance cycle) and ignored when busy. A host write and command accept on the same edge both take effect; the command's beat 0 sees the new data.
- dbg ports are pure combinational reads of current state and have no side effects.

Test Plan:
- Host writes mem[0..15]=1..16; LOAD rd=1 addr=0 -> done 5 cycles after accept (defaults), err=0; reg1 lanes = 1..16; cmd_ready low for 4 cycles.
- LOAD r0 from addr 16 (values 100..115), ADD rd=2 rs1=0 rs2=1 -> reg2 lane i = 101+2i. SUB with r0=0, r1=1 -> lanes = 0xFFFFFFFF.
- MUL rd=3, rs1 lanes 0xFFFFFFFF, rs2 lanes 2 -> reg3 lanes 0xFFFFFFFE; reg0 (wrap of rd+1) lanes 0x00000001.
- LOAD addr=497 -> done=1 and err=1 the cycle after accept, no registers changed. Addr=496 succeeds with the last element from mem[511].
- STORE rd=1 addr=32, rst_n low after 2 beats -> mem[32..39] updated, mem[40..47] unchanged, no done, regs cleared, cmd_ready=1 after release.
- Illegal op 110 -> done+err pulse. host_we during EXEC -> memory unchanged (check via dbg_mem_data).

Source files
------------

// File: rtl/vector_engine_if.sv
// vector_engine_if: command handshake and completion status of the vector engine
interface vector_engine_if #(
   parameter int MEM_AW = 9,
   parameter int REG_AW = 2
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [MEM_AW-1:0] cmd_addr;
   logic [REG_AW-1:0] cmd_rd;
   logic [REG_AW-1:0] cmd_rs1;
   logic [REG_AW-1:0] cmd_rs2;
   logic              done;
   logic              err;
   logic              busy;
   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_rd, cmd_rs1, cmd_rs2,
      input  cmd_ready, done, err, busy
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_rd, cmd_rs1, cmd_rs2,
      output cmd_ready, done, err, busy
   );
endinterface

// File: rtl/vector_engine.sv
// vector_engine: beat-serial vector load/store/ALU engine with scratch memory and register file
module vector_engine #(
   parameter int NUM_REGS       = 4,
   parameter int LANES          = 16,
   parameter int ELEM_W         = 32,
   parameter int MEM_DEPTH      = 512,
   parameter int LANES_PER_BEAT = 4,
   localparam int REG_AW  = $clog2(NUM_REGS),
   localparam int MEM_AW  = $clog2(MEM_DEPTH),
   localparam int LANE_AW = $clog2(LANES),
   localparam int BEATS   = LANES / LANES_PER_BEAT,
   localparam int BEAT_W  = BEATS > 1 ? $clog2(BEATS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   vector_engine_if.slave     bus,
   input  logic               host_we,
   input  logic [MEM_AW-1:0]  host_addr,
   input  logic [ELEM_W-1:0]  host_wdata,
   input  logic [MEM_AW-1:0]  dbg_mem_addr,
   output logic [ELEM_W-1:0]  dbg_mem_data,
   input  logic [REG_AW-1:0]  dbg_reg,
   input  logic [LANE_AW-1:0] dbg_lane,
   output logic [ELEM_W-1:0]  dbg_reg_data
);
   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_STORE = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_MUL   = 3'd3;
   localparam logic [2:0] OP_SUB   = 3'd4;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t              state, state_nx;
   logic [BEAT_W-1:0]   beat, beat_nx;
   logic                done_q, done_nx, err_q, err_nx;
   logic [2:0]          op_q;
   logic [MEM_AW-1:0]   addr_q;
   logic [REG_AW-1:0]   rd_q, rs1_q, rs2_q;
   logic [REG_AW-1:0]   rd_hi;
   logic                accept, reject, ldst, oob, last;

   logic [ELEM_W-1:0]   mem  [MEM_DEPTH];
   logic [ELEM_W-1:0]   regs [NUM_REGS][LANES];

   logic [LANE_AW-1:0]  lane_idx [LANES_PER_BEAT];
   logic [MEM_AW-1:0]   mem_idx  [LANES_PER_BEAT];
   logic [ELEM_W-1:0]   opa      [LANES_PER_BEAT];
   logic [ELEM_W-1:0]   opb      [LANES_PER_BEAT];
   logic [2*ELEM_W-1:0] prod     [LANES_PER_BEAT];
   logic [ELEM_W-1:0]   res_lo   [LANES_PER_BEAT];

   assign bus.cmd_ready = rst_n && state == IDLE;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.busy      = state == EXEC;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign ldst          = bus.cmd_op == OP_LOAD || bus.cmd_op == OP_STORE;
   assign oob           = ({1'b0, bus.cmd_addr} + (MEM_AW+1)'(LANES)) > (MEM_AW+1)'(MEM_DEPTH);
   assign reject        = bus.cmd_op > OP_SUB || (ldst && oob);
   assign last          = beat == BEAT_W'(BEATS - 1);
   assign rd_hi         = rd_q + REG_AW'(1);
   assign dbg_mem_data  = mem[dbg_mem_addr];
   assign dbg_reg_data  = regs[dbg_reg][dbg_lane];

   // State, beat counter and completion pulses; reset aborts any command in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         beat   <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         beat   <= beat_nx;
         done_q <= done_nx;
         err_q  <= err_nx;
      end
   end

   // Next state: accept or reject in IDLE, step through the beats in EXEC
   always_comb begin
      state_nx = state;
      beat_nx  = beat;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      if (state == IDLE) begin
         done_nx  = accept && reject;
         err_nx   = accept && reject;
         state_nx = accept && !reject ? EXEC : IDLE;
         beat_nx  = '0;
      end else begin
         done_nx  = last;
         state_nx = last ? IDLE : EXEC;
         beat_nx  = last ? '0 : beat + BEAT_W'(1);
      end
   end

   // Capture the command so the host may change the inputs once it is accepted
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= bus.cmd_op;
         addr_q <= bus.cmd_addr;
         rd_q   <= bus.cmd_rd;
         rs1_q  <= bus.cmd_rs1;
         rs2_q  <= bus.cmd_rs2;
      end
   end

   // Per-lane results for the slice of lanes owned by the current beat
   always_comb begin
      for (int j = 0; j < LANES_PER_BEAT; j++) begin
         lane_idx[j] = LANE_AW'(int'(beat) * LANES_PER_BEAT + j);
         mem_idx[j]  = addr_q + MEM_AW'(lane_idx[j]);
         opa[j]      = regs[rs1_q][lane_idx[j]];
         opb[j]      = regs[rs2_q][lane_idx[j]];
         prod[j]     = (2*ELEM_W)'(opa[j]) * (2*ELEM_W)'(opb[j]);
         res_lo[j]   = op_q == OP_LOAD ? mem[mem_idx[j]] :
                       op_q == OP_ADD  ? opa[j] + opb[j] :
                       op_q == OP_SUB  ? opa[j] - opb[j] : prod[j][ELEM_W-1:0];
      end
   end

   // Register file: cleared on reset, one lane slice written per beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++)
            for (int l = 0; l < LANES; l++)
               regs[r][l] <= '0;
      end else if (state == EXEC && op_q != OP_STORE) begin
         for (int j = 0; j < LANES_PER_BEAT; j++) begin
            regs[rd_q][lane_idx[j]] <= res_lo[j];
            if (op_q == OP_MUL)
               regs[rd_hi][lane_idx[j]] <= prod[j][2*ELEM_W-1:ELEM_W];
         end
      end
   end

   // Scratch memory: host writes while idle, store beats while executing, never cleared
   always_ff @(posedge clk) begin
      if (state == IDLE && host_we)
         mem[host_addr] <= host_wdata;
      else if (rst_n && state == EXEC && op_q == OP_STORE)
         for (int j = 0; j < LANES_PER_BEAT; j++)
            mem[mem_idx[j]] <= regs[rd_q][lane_idx[j]];
   end
endmodule

// File: tb/tb_vector_engine.sv
// tb_vector_engine: directed vectors for the vector engine with hand-computed expectations
module tb_vector_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        host_we = 1'b0;
   logic [8:0]  host_addr = '0;
   logic [31:0] host_wdata = '0;
   logic [8:0]  dbg_mem_addr = '0;
   logic [31:0] dbg_mem_data;
   logic [1:0]  dbg_reg = '0;
   logic [3:0]  dbg_lane = '0;
   logic [31:0] dbg_reg_data;
   int          n_vec = 0;
   int          n_err = 0;
   int          lat, nr;
   logic        e, seen;

   always #5 clk = ~clk;

   vector_engine_if #(.MEM_AW(9), .REG_AW(2)) bus ();

   vector_engine dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data),
      .dbg_reg(dbg_reg), .dbg_lane(dbg_lane), .dbg_reg_data(dbg_reg_data)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [8:0] a, input logic [31:0] d);
      host_we = 1'b1;
      host_addr = a;
      host_wdata = d;
      tick;
      host_we = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] r, input int l, input logic [31:0] exp);
      dbg_reg = r;
      dbg_lane = 4'(l);
      #1;
      chk(tag, dbg_reg_data, exp);
   endtask

   task automatic check_mem(input string tag, input logic [8:0] a, input logic [31:0] exp);
      dbg_mem_addr = a;
      #1;
      chk(tag, dbg_mem_data, exp);
   endtask

   task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [8:0] addr, input logic poke,
                      output int lat_o, output logic err_o, output int nr_o);
      bus.cmd_op = op;
      bus.cmd_rd = rd;
      bus.cmd_rs1 = rs1;
      bus.cmd_rs2 = rs2;
      bus.cmd_addr = addr;
      bus.cmd_valid = 1'b1;
      tick;
      bus.cmd_valid = 1'b0;
      lat_o = 1;
      nr_o = 0;
      if (poke) begin
         host_we = 1'b1;
         host_addr = 9'd200;
         host_wdata = 32'h55;
      end
      while (!bus.done && lat_o < 20) begin
         nr_o += int'(!bus.cmd_ready);
         tick;
         host_we = 1'b0;
         lat_o++;
      end
      host_we = 1'b0;
      err_o = bus.err;
      chk("done_seen", bus.done, 1);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op = '0;
      bus.cmd_addr = '0;
      bus.cmd_rd = '0;
      bus.cmd_rs1 = '0;
      bus.cmd_rs2 = '0;
      tick;
      tick;
      chk("rst_ready", bus.cmd_ready, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_busy", bus.busy, 0);
      check_reg("rst_reg", 2'd1, 0, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", bus.cmd_ready, 1);
      tick;

      for (int i = 0; i < 16; i++) host_write(9'(i), 32'(i + 1));
      for (int i = 0; i < 16; i++) host_write(9'(16 + i), 32'(100 + i));
      for (int i = 0; i < 16; i++) host_write(9'(48 + i), 32'h0);
      for (int i = 0; i < 16; i++) host_write(9'(64 + i), 32'h1);
      for (int i = 0; i < 16; i++) host_write(9'(80 + i), 32'h2);
      for (int i = 0; i < 16; i++) host_write(9'(32 + i), 32'hC00 + 32'(i));
      for (int i = 0; i < 16; i++) host_write(9'(496 + i), 32'h500 + 32'(i));
      host_write(9'd200, 32'hAA);

      run(3'b000, 2'd1, 2'd0, 2'd0, 9'd0, 1'b0, lat, e, nr);
      chk("load_lat", 64'(lat), 5);
      chk("load_err", e, 0);
      chk("load_notready", 64'(nr), 4);
      tick;
      chk("done_pulse_width", bus.done, 0);
      for (int i = 0; i < 16; i++) check_reg("load_r1", 2'd1, i, 32'(i + 1));

      run(3'b000, 2'd0, 2'd0, 2'd0, 9'd16, 1'b0, lat, e, nr);
      run(3'b010, 2'd2, 2'd0, 2'd1, 9'd0, 1'b0, lat, e, nr);
      chk("add_lat", 64'(lat), 5);
      for (int i = 0; i < 16; i++) check_reg("add_r2", 2'd2, i, 32'(101 + 2 * i));

      run(3'b000, 2'd0, 2'd0, 2'd0, 9'd48, 1'b0, lat, e, nr);
      run(3'b000, 2'd1, 2'd0, 2'd0, 9'd64, 1'b0, lat, e, nr);
      run(3'b100, 2'd2, 2'd0, 2'd1, 9'd0, 1'b0, lat, e, nr);
      for (int i = 0; i < 16; i += 5) check_reg("sub_r2", 2'd2, i, 32'hFFFF_FFFF);

      run(3'b000, 2'd1, 2'd0, 2'd0, 9'd80, 1'b0, lat, e, nr);
      run(3'b011, 2'd3, 2'd2, 2'd1, 9'd0, 1'b0, lat, e, nr);
      chk("mul_err", e, 0);
      for (int i = 0; i < 16; i += 5) check_reg("mul_lo_r3", 2'd3, i, 32'hFFFF_FFFE);
      for (int i = 0; i < 16; i += 5) check_reg("mul_hi_r0", 2'd0, i, 32'h1);

      run(3'b010, 2'd0, 2'd0, 2'd0, 9'd0, 1'b0, lat, e, nr);
      for (int i = 0; i < 16; i += 5) check_reg("add_overlap_r0", 2'd0, i, 32'h2);

      run(3'b000, 2'd3, 2'd0, 2'd0, 9'd497, 1'b0, lat, e, nr);
      chk("oob_lat", 64'(lat), 1);
      chk("oob_err", e, 1);
      check_reg("oob_r3_l0", 2'd3, 0, 32'hFFFF_FFFE);
      check_reg("oob_r3_l15", 2'd3, 15, 32'hFFFF_FFFE);
      chk("oob_idle", bus.cmd_ready, 1);

      run(3'b000, 2'd3, 2'd0, 2'd0, 9'd496, 1'b0, lat, e, nr);
      chk("edge_lat", 64'(lat), 5);
      chk("edge_err", e, 0);
      check_reg("edge_r3_l0", 2'd3, 0, 32'h500);
      check_reg("edge_r3_l15", 2'd3, 15, 32'h50F);

      run(3'b110, 2'd0, 2'd0, 2'd0, 9'd0, 1'b0, lat, e, nr);
      chk("illegal_lat", 64'(lat), 1);
      chk("illegal_err", e, 1);
      check_reg("illegal_r0", 2'd0, 0, 32'h2);

      run(3'b001, 2'd3, 2'd0, 2'd0, 9'd112, 1'b1, lat, e, nr);
      chk("store_lat", 64'(lat), 5);
      chk("store_err", e, 0);
      check_mem("host_we_busy", 9'd200, 32'hAA);
      for (int i = 0; i < 16; i++) check_mem("store_mem", 9'(112 + i), 32'h500 + 32'(i));

      bus.cmd_op = 3'b001;
      bus.cmd_rd = 2'd1;
      bus.cmd_addr = 9'd32;
      bus.cmd_valid = 1'b1;
      tick;
      bus.cmd_valid = 1'b0;
      chk("abort_busy", bus.busy, 1);
      tick;
      tick;
      rst_n = 1'b0;
      tick;
      chk("abort_done", bus.done, 0);
      chk("abort_ready_in_rst", bus.cmd_ready, 0);
      chk("abort_busy_cleared", bus.busy, 0);
      rst_n = 1'b1;
      #1;
      chk("abort_ready", bus.cmd_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         seen = seen | bus.done;
      end
      chk("abort_no_done", seen, 0);
      for (int i = 0; i < 8; i++) check_mem("abort_written", 9'(32 + i), 32'h2);
      for (int i = 8; i < 16; i++) check_mem("abort_kept", 9'(32 + i), 32'hC00 + 32'(i));
      check_reg("abort_r1_clr", 2'd1, 0, 32'h0);
      check_reg("abort_r3_clr", 2'd3, 15, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
